csr_gpio_ctrl: RTL and testbench

CSR_GPIO_CTRL -- requirements
Module: csr_gpio_ctrl

---
 rtl/decoder_pkg.sv | 19 +
 rtl/gpio_pkg.sv | 14 +
 rtl/gpio_sync.sv | 54 +++++
 rtl/csr_gpio_ctrl.sv | 117 +++++++++++
 tb/tb_csr_gpio_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared CSR decoder types: address, data word, immediate field and op encoding.
package decoder_pkg;

    typedef logic [11:0] CsrAddrT;
    typedef logic [31:0] word;
    typedef logic [4:0]  r;

    // Bit 2 selects the immediate form; bits 1:0 pick write/set/clear.
    typedef enum logic [2:0] {
        CSR_NONE = 3'b000,
        CSR_RW   = 3'b001,
        CSR_RS   = 3'b010,
        CSR_RC   = 3'b011,
        CSR_RWI  = 3'b101,
        CSR_RSI  = 3'b110,
        CSR_RCI  = 3'b111
    } csr_op_t;

endpackage

// File: rtl/gpio_pkg.sv
// GPIO controller defaults and CSR map, built on the decoder types.
package gpio_pkg;

    localparam int GPIO_NUM_DEF    = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam decoder_pkg::CsrAddrT DIR_ADDR     = 12'h7C0;
    localparam decoder_pkg::CsrAddrT DATA_ADDR    = 12'h7C1;
    localparam decoder_pkg::CsrAddrT IN_ADDR      = 12'h7C2;
    localparam decoder_pkg::CsrAddrT RISE_EN_ADDR = 12'h7C3;
    localparam decoder_pkg::CsrAddrT FALL_EN_ADDR = 12'h7C4;
    localparam decoder_pkg::CsrAddrT PEND_ADDR    = 12'h7C5;

endpackage

// File: rtl/gpio_sync.sv
// Pin synchroniser, post-reset warm-up counter and edge detector.
module gpio_sync #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] i_async,
    output logic [Width-1:0] o_in,
    output logic [Width-1:0] o_rise,
    output logic [Width-1:0] o_fall,
    output logic             o_armed
);

    // The counter stops one cycle after the chain and prev have both filled,
    // so the fill-in transition from reset zeros never counts as an edge.
    localparam int WarmMax = Depth + 1;
    localparam int CntW    = $clog2(WarmMax + 1);

    logic [Width-1:0] r_sync [Depth];
    logic [Width-1:0] r_prev;
    logic [CntW-1:0]  r_warm;

    // Synchroniser chain plus one-cycle-delayed copy of its output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < Depth; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[Depth-1];
        end
    end

    // Warm-up counter, saturating at WarmMax.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm <= '0;
        end else if (r_warm != CntW'(WarmMax)) begin
            r_warm <= r_warm + CntW'(1);
        end
    end

    assign o_in    = r_sync[Depth-1];
    assign o_rise  = r_sync[Depth-1] & ~r_prev;
    assign o_fall  = ~r_sync[Depth-1] & r_prev;
    assign o_armed = (r_warm == CntW'(WarmMax));

endmodule

// File: rtl/csr_gpio_ctrl.sv
// CSR-mapped GPIO block: direction/data registers, pin drive, edge interrupts.
module csr_gpio_ctrl
    import decoder_pkg::*, gpio_pkg::*;
#(
    parameter int      GpioNum    = GPIO_NUM_DEF,
    parameter int      SyncStages = SYNC_STAGES_DEF,
    parameter CsrAddrT DirAddr    = DIR_ADDR,
    parameter CsrAddrT DataAddr   = DATA_ADDR,
    parameter CsrAddrT InAddr     = IN_ADDR,
    parameter CsrAddrT RiseEnAddr = RISE_EN_ADDR,
    parameter CsrAddrT FallEnAddr = FALL_EN_ADDR,
    parameter CsrAddrT PendAddr   = PEND_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               csr_enable,
    input  CsrAddrT            csr_addr,
    input  r                   rs1_zimm,
    input  word                rs1_data,
    input  csr_op_t            csr_op,
    input  logic [GpioNum-1:0] ext_data,
    input  logic               ext_write_enable,
    output word                out,
    output logic               irq,
    inout  wire  [GpioNum-1:0] io
);

    logic [GpioNum-1:0] r_dir, r_data, r_rise_en, r_fall_en, r_pend;

    logic [GpioNum-1:0] w_in, w_rise, w_fall;
    logic               w_armed;

    word                w_src_word;
    logic [GpioNum-1:0] w_src, w_old, w_result, w_pend_keep, w_set, w_pend_next;
    logic               w_hit, w_wr;

    gpio_sync #(
        .Width (GpioNum),
        .Depth (SyncStages)
    ) u_sync (
        .clk     (clk),
        .rst_n   (reset),
        .i_async (io),
        .o_in    (w_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_armed (w_armed)
    );

    // Decode the access: operand, addressed register, write result and strobe.
    always_comb begin
        w_src_word = csr_op[2] ? word'(rs1_zimm) : rs1_data;
        w_src      = GpioNum'(w_src_word);
        w_old      = '0;
        w_hit      = 1'b1;
        if      (csr_addr == DirAddr)    w_old = r_dir;
        else if (csr_addr == DataAddr)   w_old = r_data;
        else if (csr_addr == InAddr)     w_old = w_in;
        else if (csr_addr == RiseEnAddr) w_old = r_rise_en;
        else if (csr_addr == FallEnAddr) w_old = r_fall_en;
        else if (csr_addr == PendAddr)   w_old = r_pend;
        else                             w_hit = 1'b0;

        w_result = w_old;
        w_wr     = 1'b0;
        case (csr_op)
            CSR_RW, CSR_RWI: begin
                w_result = w_src;
                w_wr     = 1'b1;
            end
            CSR_RS, CSR_RSI: begin
                w_result = w_old | w_src;
                w_wr     = (w_src != '0);
            end
            CSR_RC, CSR_RCI: begin
                w_result = w_old & ~w_src;
                w_wr     = (w_src != '0);
            end
            default: ;
        endcase
        // IN is read-only, so a hit there never becomes a write.
        w_wr = w_wr && csr_enable && w_hit && (csr_addr != InAddr);
    end

    // Pending update: a new event outranks a simultaneous software clear.
    always_comb begin
        w_pend_keep = (w_wr && csr_addr == PendAddr) ? w_result : '1;
        w_set       = w_armed ? ((w_rise & r_rise_en) | (w_fall & r_fall_en)) : '0;
        w_pend_next = (r_pend & w_pend_keep) | w_set;
    end

    // CSR register file; software writes to DATA beat the hardware port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dir     <= '0;
            r_data    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_pend    <= '0;
        end else begin
            if (w_wr && csr_addr == DirAddr)    r_dir     <= w_result;
            if (w_wr && csr_addr == RiseEnAddr) r_rise_en <= w_result;
            if (w_wr && csr_addr == FallEnAddr) r_fall_en <= w_result;
            if (w_wr && csr_addr == DataAddr)   r_data    <= w_result;
            else if (ext_write_enable)          r_data    <= ext_data;
            r_pend <= w_pend_next;
        end
    end

    for (genvar k = 0; k < GpioNum; k++) begin : g_pin
        assign io[k] = r_dir[k] ? r_data[k] : 1'bz;
    end

    assign out = (csr_enable && w_hit) ? word'(w_old) : '0;
    assign irq = |r_pend;

endmodule

// File: tb/tb_csr_gpio_ctrl.sv
// Directed bench for csr_gpio_ctrl with an expected-value queue.
module tb_csr_gpio_ctrl;
    import decoder_pkg::*, gpio_pkg::*;

    localparam int SYNC = SYNC_STAGES_DEF;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       csr_enable;
    CsrAddrT    csr_addr;
    r           rs1_zimm;
    word        rs1_data;
    csr_op_t    csr_op;
    logic [7:0] ext_data;
    logic       ext_write_enable;
    word        rd_out;
    logic       irq;
    wire  [7:0] io;

    logic [7:0] tb_oe;
    logic [7:0] tb_val;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 8; k++) begin : g_drv
        assign io[k] = tb_oe[k] ? tb_val[k] : 1'bz;
    end

    csr_gpio_ctrl dut (
        .clk              (clk),
        .reset            (reset_n),
        .csr_enable       (csr_enable),
        .csr_addr         (csr_addr),
        .rs1_zimm         (rs1_zimm),
        .rs1_data         (rs1_data),
        .csr_op           (csr_op),
        .ext_data         (ext_data),
        .ext_write_enable (ext_write_enable),
        .out              (rd_out),
        .irq              (irq),
        .io               (io)
    );

    task automatic push(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic csr_write(input csr_op_t op, input CsrAddrT a, input word d, input r z,
                             input logic ewe, input logic [7:0] ed);
        @(negedge clk);
        csr_enable       = (op != CSR_NONE);
        csr_op           = op;
        csr_addr         = a;
        rs1_data         = d;
        rs1_zimm         = z;
        ext_write_enable = ewe;
        ext_data         = ed;
        @(negedge clk);
        csr_enable       = 1'b0;
        csr_op           = CSR_NONE;
        rs1_data         = '0;
        rs1_zimm         = '0;
        ext_write_enable = 1'b0;
        ext_data         = '0;
    endtask

    task automatic csr_read(input CsrAddrT a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        csr_enable = 1'b1;
        csr_op     = CSR_RS;
        csr_addr   = a;
        rs1_data   = '0;
        rs1_zimm   = '0;
        push(tag, exp);
        #1;
        check(rd_out);
        csr_enable = 1'b0;
        csr_op     = CSR_NONE;
    endtask

    task automatic check_irq(input logic exp, input string tag);
        push(tag, {31'b0, exp});
        check({31'b0, irq});
    endtask

    initial begin
        reset_n          = 1'b0;
        csr_enable       = 1'b0;
        csr_op           = CSR_NONE;
        csr_addr         = '0;
        rs1_data         = '0;
        rs1_zimm         = '0;
        ext_data         = '0;
        ext_write_enable = 1'b0;
        tb_oe            = 8'hFF;
        tb_val           = 8'hFF;

        // Reset with all pins pulled high; warm-up must hide the fill-in edges.
        repeat (3) @(negedge clk);
        check_irq(1'b0, "irq_in_reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_irq(1'b0, "irq_after_warmup");
        csr_read(PEND_ADDR, 32'h0,  "pend_after_reset");
        csr_read(IN_ADDR,   32'hFF, "in_after_reset");
        csr_read(DIR_ADDR,  32'h0,  "dir_after_reset");

        // Low nibble driven by the DUT, high nibble by the bench.
        tb_oe  = 8'hF0;
        tb_val = 8'h30;
        csr_write(CSR_RW, DIR_ADDR,  32'h0F, 5'd0, 1'b0, 8'h00);
        csr_write(CSR_RW, DATA_ADDR, 32'hA5, 5'd0, 1'b0, 8'h00);
        push("io_low_nibble", 32'h5);
        check({28'b0, io[3:0]});
        csr_read(DATA_ADDR, 32'hA5, "data_rw");
        repeat (SYNC + 1) @(negedge clk);
        csr_read(IN_ADDR, 32'h35, "in_mixed_drive");

        // Set/clear forms, register and immediate, plus zero-operand no-op.
        csr_write(CSR_RS,  DATA_ADDR, 32'h08, 5'd0, 1'b0, 8'h00);
        csr_read(DATA_ADDR, 32'hAD, "data_rs");
        csr_write(CSR_RCI, DATA_ADDR, 32'hFF, 5'd5, 1'b0, 8'h00);
        csr_read(DATA_ADDR, 32'hA8, "data_rci");
        csr_write(CSR_RC,  DATA_ADDR, 32'h100, 5'd0, 1'b0, 8'h00);
        csr_read(DATA_ADDR, 32'hA8, "data_rc_zero_src");

        // Unmapped address: read zero, write goes nowhere.
        csr_write(CSR_RW, 12'h7FF, 32'hFF, 5'd0, 1'b0, 8'h00);
        csr_read(12'h7FF,  32'h0,  "unmatched_read");
        csr_read(DIR_ADDR, 32'h0F, "dir_after_unmatched");

        // Hand all pins back to the bench, low.
        csr_write(CSR_RW, DIR_ADDR, 32'h00, 5'd0, 1'b0, 8'h00);
        tb_oe  = 8'hFF;
        tb_val = 8'h00;
        repeat (6) @(negedge clk);
        csr_read(PEND_ADDR, 32'h0, "pend_no_enables");

        // Rising edge on pin 0: PEND appears exactly SYNC+1 edges later.
        csr_write(CSR_RWI, RISE_EN_ADDR, 32'h0, 5'd1, 1'b0, 8'h00);
        tb_val[0] = 1'b1;
        for (int i = 1; i <= SYNC + 1; i++) begin
            @(posedge clk);
            #1;
            check_irq(i == SYNC + 1, "irq_rise_latency");
        end
        csr_read(PEND_ADDR, 32'h01, "pend_rise");
        csr_write(CSR_RW, RISE_EN_ADDR, 32'h0, 5'd0, 1'b0, 8'h00);
        csr_read(PEND_ADDR, 32'h01, "pend_kept_after_disable");

        // Fall event lands in the same cycle as a clear of PEND[0].
        csr_write(CSR_RW, FALL_EN_ADDR, 32'h01, 5'd0, 1'b0, 8'h00);
        tb_val[0] = 1'b0;
        repeat (SYNC - 1) @(negedge clk);
        csr_write(CSR_RC, PEND_ADDR, 32'h01, 5'd0, 1'b0, 8'h00);
        csr_read(PEND_ADDR, 32'h01, "pend_set_beats_clear");
        check_irq(1'b1, "irq_set_beats_clear");
        csr_write(CSR_RC, PEND_ADDR, 32'h01, 5'd0, 1'b0, 8'h00);
        csr_read(PEND_ADDR, 32'h00, "pend_cleared");
        check_irq(1'b0, "irq_cleared");

        // DATA arbitration between software and hardware writers.
        csr_write(CSR_RSI, DATA_ADDR, 32'h0, 5'd0, 1'b1, 8'h3C);
        csr_read(DATA_ADDR, 32'h3C, "data_ext_vs_rsi_zero");
        csr_write(CSR_RW, DATA_ADDR, 32'h11, 5'd0, 1'b1, 8'h22);
        csr_read(DATA_ADDR, 32'h11, "data_csr_beats_ext");
        csr_write(CSR_NONE, DATA_ADDR, 32'h0, 5'd0, 1'b1, 8'h5A);
        csr_read(DATA_ADDR, 32'h5A, "data_ext_only");

        // Asynchronous reset mid-cycle clears state without a clock edge.
        tb_oe = 8'h00;
        csr_write(CSR_RW, DIR_ADDR, 32'hFF, 5'd0, 1'b0, 8'h00);
        @(posedge clk);
        #2;
        reset_n    = 1'b0;
        #1;
        csr_enable = 1'b1;
        csr_op     = CSR_RS;
        csr_addr   = DATA_ADDR;
        push("data_async_reset", 32'h0);
        #0.5;
        check(rd_out);
        csr_addr   = DIR_ADDR;
        push("dir_async_reset", 32'h0);
        #0.5;
        check(rd_out);
        csr_enable = 1'b0;
        csr_op     = CSR_NONE;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
